// File: rtl/aes_dec_round.sv
// Iterative AES-128 inverse cipher: ten forward key-expansion cycles, one whitening
// cycle, then ten inverse rounds that unwind the key schedule on the fly.
module aes_dec_round (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] IN,
  input  logic [127:0] KEY,
  output logic [127:0] DEC,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ARK, ROUND} state_t;

  state_t       state, state_next;
  logic [127:0] st, rk;
  logic [3:0]   rc;
  logic [127:0] rk_fwd, pk, t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
    return b[127 - 8*i -: 8];
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rcon(r), 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Recovers round key i-1 from round key i; p3 equals the old w3 fed to RotWord.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rcon(r), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = inv_sbox(byte_of(s, r + 4*((c - r + 4) % 4)));
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = byte_of(s, 4*c);
      a1 = byte_of(s, 4*c + 1);
      a2 = byte_of(s, 4*c + 2);
      a3 = byte_of(s, 4*c + 3);
      o[127 - 32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  assign rk_fwd = key_fwd(rk, rc);
  assign pk     = key_inv(rk, rc);
  assign t      = inv_shift_sub(st) ^ pk;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: default first so every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = KEYEXP;
      KEYEXP:  if (rc == 4'd10) state_next = ARK;
      ARK:     state_next = ROUND;
      ROUND:   if (rc == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the design holds only flat registers, so everything is cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= '0;
      rk   <= '0;
      rc   <= '0;
      DEC  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            st   <= IN;
            rk   <= KEY;
            rc   <= 4'd1;
            busy <= 1'b1;
          end
        end
        KEYEXP: begin
          rk <= rk_fwd;
          rc <= rc + 4'd1;
        end
        ARK: begin
          st <= st ^ rk;
          rc <= 4'd10;
        end
        ROUND: begin
          rk <= pk;
          rc <= rc - 4'd1;
          if (rc == 4'd1) begin
            st   <= t;
            DEC  <= t;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            st <= inv_mix(t);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_round.sv
// Scoreboard bench for aes_dec_round: FIPS-197 vectors, reset behaviour and random
// round-trips against a table-driven AES model built from GF(2^8) arithmetic.
module tb_aes_dec_round;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] in_blk = '0;
  logic [127:0] key = '0;
  logic [127:0] dec;
  logic         busy, done;

  always #5 clk = ~clk;

  aes_dec_round dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .IN   (in_blk),
    .KEY  (key),
    .DEC  (dec),
    .busy (busy),
    .done (done)
  );

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t[256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
    return b ^ 8'h63;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      s = affine(inv);
      sbox_t[a]  = s;
      isbox_t[s] = 8'(a);
    end
  endtask

  function automatic int bi(input int r, input int c);
    return 127 - 8*(r + 4*c);
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rcv;
    rcv = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rcv;
        rcv = gmul(rcv, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] blk_sub(input logic [127:0] b, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = inv ? isbox_t[b[127 - 8*i -: 8]] : sbox_t[b[127 - 8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] blk_shift(input logic [127:0] b, input bit inv);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (inv) o[bi(r, (c + r) % 4) -: 8] = b[bi(r, c) -: 8];
        else     o[bi(r, c) -: 8] = b[bi(r, (c + r) % 4) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] blk_mix(input logic [127:0] b, input bit inv);
    logic [7:0]   m[4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - i + 4) % 4], b[bi(j, c) -: 8]);
        o[bi(i, c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] b;
    b = pt ^ round_key(k, 0);
    for (int n = 1; n <= 10; n++) begin
      b = blk_shift(blk_sub(b, 1'b0), 1'b0);
      if (n < 10) b = blk_mix(b, 1'b0);
      b = b ^ round_key(k, n);
    end
    return b;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic do_start(input logic [127:0] ct, input logic [127:0] k,
                          input logic [127:0] exp_pt, output int c0);
    exp_t e;
    @(negedge clk);
    in_blk = ct;
    key    = k;
    start  = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    e.pt  = exp_pt;
    e.due = c0 + 21;
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    in_blk = rand128();
    key    = rand128();
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles, required 0",
               sb.size(), max_cycles);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    logic prev_done = 1'b0;
    int   busy_run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_run  = 0;
        prev_done = 1'b0;
      end else begin
        if (done) begin
          check("done_width", {127'b0, prev_done}, 128'b0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
          end else begin
            e = sb.pop_front();
            check("dec", dec, e.pt);
            check_int("done_cycle", cyc, e.due);
          end
        end
        if (busy) busy_run++;
        else if (busy_run != 0) begin
          check_int("busy_len", busy_run, 21);
          busy_run = 0;
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    logic [127:0] k, pt;
    build_tables();

    // Reset held low with random activity on the inputs.
    repeat (5) begin
      @(negedge clk);
      check("rst_dec", dec, '0);
      check("rst_busy", {127'b0, busy}, '0);
      check("rst_done", {127'b0, done}, '0);
      in_blk = rand128();
      key    = rand128();
      start  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // FIPS-197 C.1 single block.
    do_start(C1_CT, C1_KEY, C1_PT, c0);
    wait_drain(40);

    // Zero key; a start pulse at E5 with fresh inputs must be ignored.
    do_start(Z_CT, '0, '0, c0);
    while (cyc < c0 + 4) @(negedge clk);
    in_blk = rand128();
    key    = rand128();
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (25) @(negedge clk);

    // FIPS-197 B with start held high: accepts every 22 cycles.
    @(negedge clk);
    in_blk = B_CT;
    key    = B_KEY;
    start  = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.pt  = B_PT;
      e.due = c0 + 21 + 22*i;
      sb.push_back(e);
    end
    while (cyc < c0 + 65) @(negedge clk);
    start = 1'b0;
    wait_drain(10);

    // Asynchronous reset in the middle of a C.1 run.
    do_start(C1_CT, C1_KEY, C1_PT, c0);
    while (cyc < c0 + 8) @(negedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check("midrst_dec", dec, '0);
    check("midrst_busy", {127'b0, busy}, '0);
    check("midrst_done", {127'b0, done}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    do_start(C1_CT, C1_KEY, C1_PT, c0);
    wait_drain(40);

    // Random round-trips through the reference encryption.
    for (int i = 0; i < 100; i++) begin
      k  = rand128();
      pt = rand128();
      do_start(aes_enc(pt, k), k, pt, c0);
      wait_drain(40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
